vga_sync_monitor: RTL and testbench

Receive-side counterpart of the VGA timing generator: samples an incoming active-low hs/vs pair, recovers the horizontal and vertical counters, and measures the line period, hsync width, frame length and vsync width. A frame-qualified lock state machine compares each frame against the 800x450 timing (1009 clocks/line, 474 lines/frame). The block sits in the pixel clock domain and serves as a self-check and as a coordinate source for overlay logic.

---
 rtl/vga_sync_monitor.sv | 142 ++++++++++++++
 tb/tb_vga_sync_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers h/v counters from an active-low hs/vs pair,
// measures line/frame timing and tracks frame-qualified lock against the expected timing.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL     = 1009,
  parameter int unsigned H_SYNC      = 80,
  parameter int unsigned V_TOTAL     = 474,
  parameter int unsigned V_SYNC      = 5,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  output logic [10:0] hc_rx,
  output logic [9:0]  vc_rx,
  output logic [10:0] h_total_meas,
  output logic [10:0] h_sync_meas,
  output logic [9:0]  v_total_meas,
  output logic [9:0]  v_sync_meas,
  output logic        locked,
  output logic        frame_pulse,
  output logic        sync_err
);

  localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_L  = 11'(H_SYNC);
  localparam logic [9:0]  V_TOTAL_L = 10'(V_TOTAL);
  localparam logic [9:0]  V_SYNC_L  = 10'(V_SYNC);
  localparam logic [3:0]  LOCK_L    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state, state_nx;
  logic [3:0]  good_cnt, good_cnt_nx, good_inc;
  logic        sync_err_nx;

  logic        hs_q, vs_q;
  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [10:0] hc_inc;
  logic [9:0]  vc_inc, vc_frame;
  logic        h_sat, v_sat;
  logic        frame_ok, frame_good, line_bad;

  assign hs_fall  = hs_q & ~hs;
  assign hs_rise  = ~hs_q & hs;
  assign vs_fall  = vs_q & ~vs;
  assign vs_rise  = ~vs_q & vs;

  assign hc_inc   = hc_rx + 11'd1;
  assign vc_inc   = vc_rx + 10'd1;
  assign vc_frame = vc_rx + {9'd0, hs_fall};
  assign h_sat    = (hc_rx == '1);
  assign v_sat    = (vc_rx == '1);
  assign good_inc = good_cnt + 4'd1;

  assign line_bad   = (hs_fall && hc_inc != H_TOTAL_L) ||
                      (hs_rise && hc_inc != H_SYNC_L)  ||
                      (vs_rise && vc_rx  != V_SYNC_L);
  assign frame_good = frame_ok & (vc_frame == V_TOTAL_L);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      hc_rx        <= '0;
      vc_rx        <= '0;
      h_total_meas <= '0;
      h_sync_meas  <= '0;
      v_total_meas <= '0;
      v_sync_meas  <= '0;
      frame_ok     <= 1'b0;
      frame_pulse  <= 1'b0;
    end else begin
      hs_q        <= hs;
      vs_q        <= vs;
      frame_pulse <= vs_fall;

      if (hs_fall)     hc_rx <= '0;
      else if (!h_sat) hc_rx <= hc_inc;

      if (vs_fall)                vc_rx <= '0;
      else if (hs_fall && !v_sat) vc_rx <= vc_inc;

      if (hs_fall) h_total_meas <= hc_inc;
      if (hs_rise) h_sync_meas  <= hc_inc;
      if (vs_fall) v_total_meas <= vc_frame;
      if (vs_rise) v_sync_meas  <= vc_rx;

      // a line closing on the same edge as vs_fall belongs to the old frame, so the set wins
      if (vs_fall)       frame_ok <= 1'b1;
      else if (line_bad) frame_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      sync_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_cnt_nx;
      sync_err <= sync_err_nx;
      locked   <= (state_nx == LOCKED);
    end
  end

  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    sync_err_nx = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nx    = ACQUIRE;
          good_cnt_nx = '0;
        end
      end
      ACQUIRE: begin
        if (h_sat || v_sat) begin
          state_nx = SEARCH;
        end else if (vs_fall) begin
          if (frame_good) begin
            good_cnt_nx = good_inc;
            if (good_inc == LOCK_L) state_nx = LOCKED;
          end else begin
            good_cnt_nx = '0;
          end
        end
      end
      LOCKED: begin
        if (h_sat || v_sat || (vs_fall && !frame_good)) begin
          state_nx    = SEARCH;
          sync_err_nx = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down 64x16 timing so full frames stay short.
module tb_vga_sync_monitor;

  localparam int HT  = 64;
  localparam int HSY = 8;
  localparam int VT  = 16;
  localparam int VSY = 3;
  localparam int LF  = 2;

  logic        clk_vga = 1'b0;
  logic        rst_n;
  logic        hs, vs;
  logic [10:0] hc_rx;
  logic [9:0]  vc_rx;
  logic [10:0] h_total_meas, h_sync_meas;
  logic [9:0]  v_total_meas, v_sync_meas;
  logic        locked, frame_pulse, sync_err;

  int n_cmp = 0;
  int n_err = 0;
  int sh, sv, line_len, vs_off;
  bit hold;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HSY), .V_TOTAL(VT), .V_SYNC(VSY), .LOCK_FRAMES(LF)
  ) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .hs(hs), .vs(vs),
    .hc_rx(hc_rx), .vc_rx(vc_rx),
    .h_total_meas(h_total_meas), .h_sync_meas(h_sync_meas),
    .v_total_meas(v_total_meas), .v_sync_meas(v_sync_meas),
    .locked(locked), .frame_pulse(frame_pulse), .sync_err(sync_err)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the source position (sh, sv), clock once, sample 1 ns after the edge, advance.
  task automatic cyc();
    if (hold) begin
      hs = 1'b1;
      vs = 1'b1;
    end else begin
      hs = (sh >= HSY);
      vs = !((sv == 0 && sh >= vs_off) || (sv >= 1 && sv < VSY) || (sv == VSY && sh < vs_off));
    end
    @(posedge clk_vga);
    #1;
    if (!hold) begin
      sh++;
      if (sh >= line_len) begin
        sh = 0;
        sv = (sv == VT - 1) ? 0 : sv + 1;
      end
    end
  endtask

  // Run up to and including the cycle that drives source position (v, h).
  task automatic run_to(input int v, input int h);
    int n = 0;
    while (!(sv == v && sh == h) && n < 4 * HT * VT) begin
      cyc();
      n++;
    end
    if (n >= 4 * HT * VT) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_to_timeout: observed %0d cycles, expected < %0d", n, 4 * HT * VT);
    end else begin
      cyc();
    end
  endtask

  task automatic nominal_lock(input string pfx);
    run_to(0, 1);
    check({pfx, "_vsf1_pulse"}, 32'(frame_pulse), 1);
    check({pfx, "_vsf1_locked"}, 32'(locked), 0);
    run_to(0, 1);
    check({pfx, "_vsf2_locked"}, 32'(locked), 0);
    check({pfx, "_h_total"}, 32'(h_total_meas), HT);
    check({pfx, "_h_sync"}, 32'(h_sync_meas), HSY);
    check({pfx, "_v_total"}, 32'(v_total_meas), VT);
    check({pfx, "_v_sync"}, 32'(v_sync_meas), VSY);
    run_to(0, 0);
    check({pfx, "_pre_vsf3_locked"}, 32'(locked), 0);
    cyc();
    check({pfx, "_vsf3_locked"}, 32'(locked), 1);
    check({pfx, "_vsf3_pulse"}, 32'(frame_pulse), 1);
    cyc();
    check({pfx, "_pulse_drop"}, 32'(frame_pulse), 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_hc"}, 32'(hc_rx), 0);
    check({pfx, "_vc"}, 32'(vc_rx), 0);
    check({pfx, "_meas"}, 32'({h_total_meas, h_sync_meas}), 0);
    check({pfx, "_vmeas"}, 32'({v_total_meas, v_sync_meas}), 0);
    check({pfx, "_flags"}, 32'({locked, frame_pulse, sync_err}), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    hs = 1'b1;
    vs = 1'b1;
    hold = 1'b0;
    vs_off = 1;
    line_len = HT;
    sh = 0;
    sv = 0;
    repeat (3) @(posedge clk_vga);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    nominal_lock("init");

    // Recovered coordinates and vertical wrap.
    run_to(5, 40);
    check("coord_hc", 32'(hc_rx), 40);
    check("coord_vc", 32'(vc_rx), 5);
    run_to(0, 0);
    check("pre_wrap_vc", 32'(vc_rx), VT);
    cyc();
    check("wrap_vc", 32'(vc_rx), 0);

    // One line stretched by a clock while locked.
    run_to(7, 0);
    line_len = HT + 1;
    run_to(8, 0);
    line_len = HT;
    check("stretch_h_total", 32'(h_total_meas), HT + 1);
    check("stretch_still_locked", 32'(locked), 1);
    run_to(0, 1);
    check("stretch_sync_err", 32'(sync_err), 1);
    check("stretch_unlocked", 32'(locked), 0);
    cyc();
    check("stretch_err_drop", 32'(sync_err), 0);
    run_to(0, 1);
    check("relock_a", 32'(locked), 0);
    run_to(0, 1);
    check("relock_b", 32'(locked), 0);
    run_to(0, 1);
    check("relock_c", 32'(locked), 1);

    // hs held high while locked: saturation of hc_rx.
    run_to(8, 20);
    hold = 1'b1;
    k = 0;
    while (hc_rx !== 11'h7FF && k < 3000) begin
      cyc();
      k++;
    end
    check("hsat_cycles", 32'(k), 2027);
    check("hsat_still_locked", 32'({locked, sync_err}), 32'b10);
    cyc();
    check("hsat_sync_err", 32'(sync_err), 1);
    check("hsat_unlocked", 32'(locked), 0);
    check("hsat_hc", 32'(hc_rx), 2047);
    cyc();
    check("hsat_err_drop", 32'(sync_err), 0);
    check("hsat_hc_hold", 32'(hc_rx), 2047);
    hold = 1'b0;

    // hs_fall and vs_fall in the same cycle.
    run_to(10, 0);
    vs_off = 0;
    run_to(15, 5);
    check("coinc_pre_vc", 32'(vc_rx), VT - 1);
    run_to(0, 0);
    check("coinc_v_total", 32'(v_total_meas), VT);
    check("coinc_vc", 32'(vc_rx), 0);
    check("coinc_pulse", 32'(frame_pulse), 1);
    run_to(1, 5);
    vs_off = 1;
    run_to(0, 1);
    check("coinc_lock_a", 32'(locked), 0);
    run_to(0, 1);
    check("coinc_lock_b", 32'(locked), 1);

    // Asynchronous reset mid-line while locked.
    run_to(6, 30);
    check("pre_rst_hc", 32'(hc_rx), 30);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    hs = 1'b1;
    vs = 1'b1;
    @(posedge clk_vga);
    #1;
    rst_n = 1'b1;
    sh = 0;
    sv = 0;
    line_len = HT;
    nominal_lock("rerst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
